// File: rtl/chime_sequencer_if.sv
// Purpose : handshake bundle between a chime controller and chime_sequencer.
// Latency : plain wires, no storage.
// Backpres: none; trig/stop are level requests sampled every clock.
// Ports   : trig, stop (requests into the sequencer); key_out, busy, done
//           (registered status/tone outputs from the sequencer).
interface chime_sequencer_if;
  logic       trig;
  logic       stop;
  logic [3:0] key_out;
  logic       busy;
  logic       done;

  // Controller side: issues requests, observes tone/status.
  modport master (
    output trig,
    output stop,
    input  key_out,
    input  busy,
    input  done
  );

  // Sequencer side.
  modport slave (
    input  trig,
    input  stop,
    output key_out,
    output busy,
    output done
  );
endinterface

// File: rtl/chime_sequencer.sv
// Purpose : plays an 8-step melody REPEAT times per trigger on an active-low
//           4-bit tone select, each step NOTE_CYC cycles of tone + GAP_CYC silent.
// Latency : first note appears one clock after trig is sampled; all outputs registered.
// Backpres: trig is ignored while busy; stop aborts at the next edge without done.
// Ports   : clk, rst_n (async active-low); bus.slave carries trig, stop,
//           key_out[3:0], busy, done.
module chime_sequencer #(
  parameter int NOTE_CYC = 12_500_000,
  parameter int GAP_CYC  = 2_500_000,
  parameter int REPEAT   = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  chime_sequencer_if.slave bus
);

  localparam int MAXC = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] NOTE_LAST = CW'(NOTE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [3:0]    REP_LAST  = 4'(REPEAT - 1);
  localparam logic [3:0]    SILENT    = 4'b1111;

  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] dur_cnt, dur_nxt;
  logic [2:0]    step, step_nxt;
  logic [3:0]    rep, rep_nxt;
  logic [3:0]    key_q, key_nxt;
  logic          busy_q, busy_nxt;
  logic          done_q, done_nxt;

  // Melody: do re mi fa mi re do rest (active-low one-cold select).
  function automatic logic [3:0] rom(input logic [2:0] idx);
    case (idx)
      3'd0:    rom = 4'b1110;
      3'd1:    rom = 4'b1101;
      3'd2:    rom = 4'b1011;
      3'd3:    rom = 4'b0111;
      3'd4:    rom = 4'b1011;
      3'd5:    rom = 4'b1101;
      3'd6:    rom = 4'b1110;
      default: rom = 4'b1111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dur_cnt <= '0;
      step    <= '0;
      rep     <= '0;
      key_q   <= SILENT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      dur_cnt <= dur_nxt;
      step    <= step_nxt;
      rep     <= rep_nxt;
      key_q   <= key_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  // Outputs are computed here as the value they must hold in the next cycle,
  // so key_out/busy/done leave the block straight from flops.
  always_comb begin
    state_nxt = state;
    dur_nxt   = dur_cnt;
    step_nxt  = step;
    rep_nxt   = rep;
    key_nxt   = key_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;

    if (bus.stop) begin
      // Abort wins over everything, including a simultaneous trig.
      state_nxt = IDLE;
      dur_nxt   = '0;
      step_nxt  = '0;
      rep_nxt   = '0;
      key_nxt   = SILENT;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          key_nxt  = SILENT;
          busy_nxt = 1'b0;
          if (bus.trig) begin
            state_nxt = NOTE;
            dur_nxt   = '0;
            step_nxt  = '0;
            rep_nxt   = '0;
            key_nxt   = rom(3'd0);
            busy_nxt  = 1'b1;
          end
        end
        NOTE: begin
          if (dur_cnt == NOTE_LAST) begin
            state_nxt = GAP;
            dur_nxt   = '0;
            key_nxt   = SILENT;
          end else begin
            dur_nxt = dur_cnt + 1'b1;
          end
        end
        GAP: begin
          if (dur_cnt == GAP_LAST) begin
            dur_nxt = '0;
            if (step != 3'd7) begin
              state_nxt = NOTE;
              step_nxt  = step + 3'd1;
              key_nxt   = rom(step + 3'd1);
            end else if (rep < REP_LAST) begin
              state_nxt = NOTE;
              rep_nxt   = rep + 4'd1;
              step_nxt  = '0;
              key_nxt   = rom(3'd0);
            end else begin
              state_nxt = IDLE;
              step_nxt  = '0;
              rep_nxt   = '0;
              key_nxt   = SILENT;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end
          end else begin
            dur_nxt = dur_cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          key_nxt   = SILENT;
          busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign bus.key_out = key_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_chime_sequencer.sv
// Purpose : self-checking bench for chime_sequencer with NOTE_CYC=4, GAP_CYC=2, REPEAT=2.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpres: n/a; trig/stop driven directly.
module tb_chime_sequencer;
  localparam int N     = 4;
  localparam int G     = 2;
  localparam int R     = 2;
  localparam int STEPC = N + G;
  localparam int TOTAL = 8 * STEPC * R;

  logic clk;
  logic rst_n;
  chime_sequencer_if bus();

  chime_sequencer #(.NOTE_CYC(N), .GAP_CYC(G), .REPEAT(R)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] melody [8] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111,
                             4'b1011, 4'b1101, 4'b1110, 4'b1111};

  // Reference model: a sequence is just "elapsed cycles since start".
  bit m_active;
  int m_el;
  bit m_done;

  function automatic logic [3:0] exp_key();
    if (!m_active) return 4'b1111;
    if ((m_el % STEPC) < N) return melody[(m_el / STEPC) % 8];
    return 4'b1111;
  endfunction

  function automatic logic exp_busy();
    return m_active;
  endfunction

  task automatic model_step(input logic t, input logic s);
    if (!rst_n) begin
      m_active = 0; m_el = 0; m_done = 0;
    end else if (s) begin
      m_active = 0; m_el = 0; m_done = 0;
    end else if (!m_active) begin
      m_done = 0;
      if (t) begin m_active = 1; m_el = 0; end
    end else begin
      m_el++;
      if (m_el == TOTAL) begin m_active = 0; m_done = 1; end
      else m_done = 0;
    end
  endtask

  // Drive inputs for the current cycle, advance one edge, then settle.
  task automatic tick(input logic t, input logic s);
    bus.trig = t;
    bus.stop = s;
    @(posedge clk);
    model_step(t, s);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.trig = 1'b0; bus.stop = 1'b0;
    m_active = 0; m_el = 0; m_done = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.key_out !== 4'b1111) begin n_fail++; $display("FAIL reset_key got=%b exp=1111", bus.key_out); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    rst_n = 1'b1;
    tick(1'b0, 1'b0);
  endtask

  task automatic test_single();
    int busy_cnt = 0;
    int done_cyc = -1;
    tick(1'b1, 1'b0);
    for (int c = 1; c <= 105; c++) begin
      n_checks++;
      if (bus.key_out !== exp_key() || bus.busy !== exp_busy() || bus.done !== m_done) begin
        n_fail++;
        $display("FAIL single cyc=%0d key=%b exp=%b busy=%b exp=%b done=%b exp=%b",
                 c, bus.key_out, exp_key(), bus.busy, exp_busy(), bus.done, m_done);
      end
      if (c == 1 && bus.key_out !== 4'b1110) begin n_fail++; $display("FAIL single_c1 key=%b exp=1110", bus.key_out); end
      if (c == 5 && bus.key_out !== 4'b1111) begin n_fail++; $display("FAIL single_c5 key=%b exp=1111", bus.key_out); end
      if (c == 7 && bus.key_out !== 4'b1101) begin n_fail++; $display("FAIL single_c7 key=%b exp=1101", bus.key_out); end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1 && done_cyc < 0) done_cyc = c;
      tick(1'b0, 1'b0);
    end
    n_checks += 3;
    n_checks++;
    if (busy_cnt != 96) begin n_fail++; $display("FAIL single_busy_len got=%0d exp=96", busy_cnt); end
    n_checks++;
    if (done_cyc != 97) begin n_fail++; $display("FAIL single_done_cyc got=%0d exp=97", done_cyc); end
  endtask

  task automatic test_stop();
    int done_seen = 0;
    tick(1'b1, 1'b0);
    for (int c = 1; c <= 120; c++) begin
      if (c == 21) begin
        n_checks++;
        if (bus.key_out !== 4'b1111 || bus.busy !== 1'b0) begin
          n_fail++; $display("FAIL stop_c21 key=%b busy=%b exp=1111/0", bus.key_out, bus.busy);
        end
      end
      n_checks++;
      if (bus.key_out !== exp_key() || bus.busy !== exp_busy() || bus.done !== m_done) begin
        n_fail++;
        $display("FAIL stop cyc=%0d key=%b exp=%b busy=%b exp=%b", c, bus.key_out, exp_key(), bus.busy, exp_busy());
      end
      if (bus.done === 1'b1) done_seen++;
      tick(1'b0, c == 20);
    end
    n_checks++;
    if (done_seen != 0) begin n_fail++; $display("FAIL stop_no_done got=%0d exp=0", done_seen); end
  endtask

  task automatic test_retrig_ignored();
    int done_cyc = -1;
    tick(1'b1, 1'b0);
    for (int c = 1; c <= 100; c++) begin
      n_checks++;
      if (bus.key_out !== exp_key() || bus.busy !== exp_busy() || bus.done !== m_done) begin
        n_fail++;
        $display("FAIL retrig cyc=%0d key=%b exp=%b busy=%b exp=%b", c, bus.key_out, exp_key(), bus.busy, exp_busy());
      end
      if (bus.done === 1'b1 && done_cyc < 0) done_cyc = c;
      tick(c == 30, 1'b0);
    end
    n_checks++;
    if (done_cyc != 97) begin n_fail++; $display("FAIL retrig_done_cyc got=%0d exp=97", done_cyc); end
  endtask

  task automatic test_trig_stop_idle();
    for (int c = 0; c < 10; c++) begin
      tick(1'b1, 1'b1);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.key_out !== 4'b1111) begin
        n_fail++; $display("FAIL trig_stop_idle busy=%b key=%b exp=0/1111", bus.busy, bus.key_out);
      end
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b0);
    for (int c = 1; c < 40; c++) tick(1'b0, 1'b0);
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre busy=%b exp=1", bus.busy); end
    #2 rst_n = 1'b0;
    m_active = 0; m_el = 0; m_done = 0;
    #1;
    n_checks++;
    if (bus.key_out !== 4'b1111 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async key=%b busy=%b exp=1111/0", bus.key_out, bus.busy);
    end
    @(posedge clk); #1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick(1'b0, 1'b0);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.key_out !== 4'b1111 || bus.done !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_idle busy=%b key=%b done=%b exp=0/1111/0", bus.busy, bus.key_out, bus.done);
      end
    end
    tick(1'b1, 1'b0);
    n_checks++;
    if (bus.key_out !== 4'b1110 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_newtrig key=%b busy=%b exp=1110/1", bus.key_out, bus.busy);
    end
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_trig_held();
    for (int c = 1; c <= 100; c++) begin
      tick(1'b1, 1'b0);
      n_checks++;
      if (bus.key_out !== exp_key() || bus.busy !== exp_busy() || bus.done !== m_done) begin
        n_fail++;
        $display("FAIL held cyc=%0d key=%b exp=%b busy=%b exp=%b done=%b exp=%b",
                 c, bus.key_out, exp_key(), bus.busy, exp_busy(), bus.done, m_done);
      end
      if (c == 97 && (bus.done !== 1'b1 || bus.busy !== 1'b0)) begin
        n_fail++; $display("FAIL held_c97 done=%b busy=%b exp=1/0", bus.done, bus.busy);
      end
      if (c == 98 && (bus.busy !== 1'b1 || bus.key_out !== 4'b1110)) begin
        n_fail++; $display("FAIL held_c98 busy=%b key=%b exp=1/1110", bus.busy, bus.key_out);
      end
    end
    n_checks += 2;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic t, s;
    for (int c = 0; c < 3000; c++) begin
      t = ($urandom_range(0, 19) == 0);
      s = ($urandom_range(0, 149) == 0);
      tick(t, s);
      n_checks++;
      if (bus.key_out !== exp_key() || bus.busy !== exp_busy() || bus.done !== m_done) begin
        n_fail++;
        $display("FAIL random cyc=%0d key=%b exp=%b busy=%b exp=%b done=%b exp=%b",
                 c, bus.key_out, exp_key(), bus.busy, exp_busy(), bus.done, m_done);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_stop();
    test_retrig_ignored();
    test_trig_stop_idle();
    test_reset_mid();
    test_trig_held();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
